// File: rtl/deadlock_stall_detector_if.sv
// Stall-vector inputs and block/debug outputs of one kernel's deadlock stall detector.
// master drives the stall vectors and observes the result; slave is the detector.
interface deadlock_stall_detector_if #(
    parameter int NUM_AXIS     = 3,
    parameter int NUM_INST     = 2,
    parameter int NUM_INST_BLK = 1,
    parameter int CNT_W        = 8
);
    logic [NUM_AXIS-1:0]              axis_block_sigs;
    logic [NUM_INST-1:0]              inst_idle_sigs;
    logic [NUM_INST_BLK-1:0]          inst_block_sigs;
    logic                             block;
    logic                             block_pulse;
    logic [CNT_W-1:0]                 stall_cnt;
    logic [NUM_AXIS-1:0]              snap_axis;
    logic [NUM_INST+NUM_INST_BLK-1:0] snap_inst;

    modport master (
        output axis_block_sigs, inst_idle_sigs, inst_block_sigs,
        input  block, block_pulse, stall_cnt, snap_axis, snap_inst
    );

    modport slave (
        input  axis_block_sigs, inst_idle_sigs, inst_block_sigs,
        output block, block_pulse, stall_cnt, snap_axis, snap_inst
    );
endinterface

// File: rtl/deadlock_stall_detector.sv
// Declares a kernel block once a stall persists with a frozen signal pattern for THRESHOLD cycles.
// block rises on the edge sampling the THRESHOLD-th frozen cycle; no backpressure, observes only.
module deadlock_stall_detector #(
    parameter int NUM_AXIS     = 3,
    parameter int NUM_INST     = 2,
    parameter int NUM_INST_BLK = 1,
    parameter int THRESHOLD    = 16,
    parameter int CNT_W        = 8,
    parameter int STICKY       = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    deadlock_stall_detector_if.slave   mon
);
    localparam int VEC_W = NUM_INST + NUM_INST_BLK + NUM_AXIS;
    localparam logic [CNT_W-1:0] THR = CNT_W'(THRESHOLD);

    typedef enum logic [1:0] {MONITOR, COUNTING, BLOCKED} state_e;

    state_e                           state_q;
    logic                             block_q;
    logic                             block_pulse_q;
    logic [CNT_W-1:0]                 stall_cnt_q;
    logic [NUM_AXIS-1:0]              snap_axis_q;
    logic [NUM_INST+NUM_INST_BLK-1:0] snap_inst_q;

    logic             stall_cond;
    logic [VEC_W-1:0] cur_vec;
    logic             same;
    logic [CNT_W-1:0] cnt_inc;

    assign stall_cond = (|mon.axis_block_sigs) | (|mon.inst_block_sigs);
    assign cur_vec    = {mon.inst_idle_sigs, mon.inst_block_sigs, mon.axis_block_sigs};
    assign same       = (cur_vec == {snap_inst_q, snap_axis_q});
    assign cnt_inc    = stall_cnt_q + CNT_W'(1);

    // Branches test "same" positively so an X compare falls into the change path.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= MONITOR;
            block_q       <= 1'b0;
            block_pulse_q <= 1'b0;
            stall_cnt_q   <= '0;
            snap_axis_q   <= '0;
            snap_inst_q   <= '0;
        end else begin
            block_pulse_q <= 1'b0;
            case (state_q)
                MONITOR: begin
                    if (stall_cond) begin
                        snap_axis_q <= mon.axis_block_sigs;
                        snap_inst_q <= {mon.inst_idle_sigs, mon.inst_block_sigs};
                        if (THRESHOLD == 1) begin
                            state_q       <= BLOCKED;
                            stall_cnt_q   <= THR;
                            block_q       <= 1'b1;
                            block_pulse_q <= 1'b1;
                        end else begin
                            state_q     <= COUNTING;
                            stall_cnt_q <= CNT_W'(1);
                        end
                    end else begin
                        stall_cnt_q <= '0;
                    end
                end
                COUNTING: begin
                    if (!stall_cond) begin
                        state_q     <= MONITOR;
                        stall_cnt_q <= '0;
                    end else if (same) begin
                        stall_cnt_q <= cnt_inc;
                        if (cnt_inc == THR) begin
                            state_q       <= BLOCKED;
                            block_q       <= 1'b1;
                            block_pulse_q <= 1'b1;
                        end
                    end else begin
                        snap_axis_q <= mon.axis_block_sigs;
                        snap_inst_q <= {mon.inst_idle_sigs, mon.inst_block_sigs};
                        stall_cnt_q <= CNT_W'(1);
                    end
                end
                BLOCKED: begin
                    // A changed pattern leaves via MONITOR; the window restarts one cycle later.
                    if (stall_cond && same) begin
                        stall_cnt_q <= THR;
                    end else if (STICKY == 0) begin
                        state_q     <= MONITOR;
                        block_q     <= 1'b0;
                        stall_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q <= MONITOR;
                end
            endcase
        end
    end

    assign mon.block       = block_q;
    assign mon.block_pulse = block_pulse_q;
    assign mon.stall_cnt   = stall_cnt_q;
    assign mon.snap_axis   = snap_axis_q;
    assign mon.snap_inst   = snap_inst_q;
endmodule

// File: tb/tb_deadlock_stall_detector.sv
// Drives three detector configurations (T=4 non-sticky, T=4 sticky, T=1) with shared stimulus
// and compares each against a run-length model of the stall rules.
module tb_deadlock_stall_detector;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    deadlock_stall_detector_if #(.NUM_AXIS(3), .NUM_INST(2), .NUM_INST_BLK(1), .CNT_W(8)) if_a ();
    deadlock_stall_detector_if #(.NUM_AXIS(3), .NUM_INST(2), .NUM_INST_BLK(1), .CNT_W(8)) if_b ();
    deadlock_stall_detector_if #(.NUM_AXIS(3), .NUM_INST(2), .NUM_INST_BLK(1), .CNT_W(8)) if_c ();

    deadlock_stall_detector #(.THRESHOLD(4), .STICKY(0)) u_a (.clock(clock), .reset(reset), .mon(if_a));
    deadlock_stall_detector #(.THRESHOLD(4), .STICKY(1)) u_b (.clock(clock), .reset(reset), .mon(if_b));
    deadlock_stall_detector #(.THRESHOLD(1), .STICKY(0)) u_c (.clock(clock), .reset(reset), .mon(if_c));

    logic       o_blk   [3];
    logic       o_pls   [3];
    logic [7:0] o_cnt   [3];
    logic [2:0] o_sax   [3];
    logic [2:0] o_sin   [3];
    assign o_blk[0] = if_a.block;       assign o_blk[1] = if_b.block;       assign o_blk[2] = if_c.block;
    assign o_pls[0] = if_a.block_pulse; assign o_pls[1] = if_b.block_pulse; assign o_pls[2] = if_c.block_pulse;
    assign o_cnt[0] = if_a.stall_cnt;   assign o_cnt[1] = if_b.stall_cnt;   assign o_cnt[2] = if_c.stall_cnt;
    assign o_sax[0] = if_a.snap_axis;   assign o_sax[1] = if_b.snap_axis;   assign o_sax[2] = if_c.snap_axis;
    assign o_sin[0] = if_a.snap_inst;   assign o_sin[1] = if_b.snap_inst;   assign o_sin[2] = if_c.snap_inst;

    int tests = 0;
    int fails = 0;

    // Reference model: per-config threshold/stickiness, run length of the frozen stall window.
    int         m_th  [3] = '{4, 4, 1};
    bit         m_stk [3] = '{0, 1, 0};
    bit         m_blk [3];
    bit         m_pls [3];
    int         m_run [3];
    logic [2:0] m_sax [3];
    logic [2:0] m_sin [3];

    logic [2:0] in_axis;
    logic [1:0] in_idle;
    logic       in_blk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        bit sc;
        bit eq;
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                m_blk[k] = 0; m_pls[k] = 0; m_run[k] = 0; m_sax[k] = '0; m_sin[k] = '0;
            end else begin
                sc = (in_axis != 0) || in_blk;
                eq = (in_axis == m_sax[k]) && ({in_idle, in_blk} == m_sin[k]);
                m_pls[k] = 0;
                if (m_blk[k]) begin
                    if (!(sc && eq) && !m_stk[k]) begin
                        m_blk[k] = 0;
                        m_run[k] = 0;
                    end
                end else if (!sc) begin
                    m_run[k] = 0;
                end else begin
                    if (m_run[k] > 0 && eq) begin
                        m_run[k]++;
                    end else begin
                        m_run[k] = 1;
                        m_sax[k] = in_axis;
                        m_sin[k] = {in_idle, in_blk};
                    end
                    if (m_run[k] == m_th[k]) begin
                        m_blk[k] = 1;
                        m_pls[k] = 1;
                    end
                end
            end
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("dut%0d_block", k),     32'(o_blk[k]), 32'(m_blk[k]));
            check($sformatf("dut%0d_pulse", k),     32'(o_pls[k]), 32'(m_pls[k]));
            check($sformatf("dut%0d_stall_cnt", k), 32'(o_cnt[k]), 32'(m_run[k]));
            check($sformatf("dut%0d_snap_axis", k), 32'(o_sax[k]), 32'(m_sax[k]));
            check($sformatf("dut%0d_snap_inst", k), 32'(o_sin[k]), 32'(m_sin[k]));
        end
    endtask

    // One clock: drive inputs, let the edge happen, then compare just after it.
    task automatic step(input logic [2:0] axis, input logic [1:0] idle, input logic blk, input logic rst);
        in_axis = axis; in_idle = idle; in_blk = blk;
        reset = rst;
        if_a.axis_block_sigs = axis; if_a.inst_idle_sigs = idle; if_a.inst_block_sigs = blk;
        if_b.axis_block_sigs = axis; if_b.inst_idle_sigs = idle; if_b.inst_block_sigs = blk;
        if_c.axis_block_sigs = axis; if_c.inst_idle_sigs = idle; if_c.inst_block_sigs = blk;
        @(posedge clock);
        model_update();
        #1;
        check_model();
    endtask

    initial begin
        logic [2:0] r_axis;
        logic [1:0] r_idle;
        logic       r_blk;
        int         r;

        step(3'b000, 2'b00, 1'b0, 1'b1);
        step(3'b000, 2'b00, 1'b0, 1'b1);
        check("reset_block", 32'(if_a.block), 32'd0);
        check("reset_cnt",   32'(if_b.stall_cnt), 32'd0);

        // Constant stall on one AXI-stream port.
        for (int i = 0; i < 6; i++) begin
            step(3'b001, 2'b00, 1'b0, 1'b0);
            check($sformatf("p1_cnt%0d", i), 32'(if_a.stall_cnt), (i < 3) ? 32'(i + 1) : 32'd4);
            check($sformatf("p1_pulse%0d", i), 32'(if_a.block_pulse), (i == 3) ? 32'd1 : 32'd0);
            check($sformatf("p1_block%0d", i), 32'(if_a.block), (i >= 3) ? 32'd1 : 32'd0);
        end

        // Pattern change mid-window restarts the count.
        step(3'b000, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(3'b010, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(3'b100, 2'b00, 1'b0, 1'b0);
            check($sformatf("p2_cnt%0d", i), 32'(if_a.stall_cnt), 32'(i + 1));
            check($sformatf("p2_block%0d", i), 32'(if_a.block), (i == 3) ? 32'd1 : 32'd0);
        end
        check("p2_snap_axis", 32'(if_a.snap_axis), 32'd4);

        // Idle-bit change while stalled also counts as progress.
        step(3'b000, 2'b00, 1'b0, 1'b1);
        step(3'b001, 2'b00, 1'b0, 1'b0);
        step(3'b001, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(3'b001, 2'b10, 1'b0, 1'b0);
            check($sformatf("p3_cnt%0d", i), 32'(if_a.stall_cnt), 32'(i + 1));
            check($sformatf("p3_block%0d", i), 32'(if_a.block), (i == 3) ? 32'd1 : 32'd0);
        end
        check("p3_snap_inst", 32'(if_a.snap_inst), 32'b100);

        // Stall resolves: non-sticky clears, sticky holds.
        for (int i = 0; i < 10; i++) begin
            step(3'b000, 2'b00, 1'b0, 1'b0);
            check($sformatf("p4_sticky_block%0d", i), 32'(if_b.block), 32'd1);
            check($sformatf("p4_nonsticky_block%0d", i), 32'(if_a.block), 32'd0);
        end
        check("p4_nonsticky_cnt", 32'(if_a.stall_cnt), 32'd0);
        for (int i = 0; i < 4; i++) step(3'b001, 2'b00, 1'b0, 1'b0);
        check("p4_second_pulse", 32'(if_a.block_pulse), 32'd1);
        step(3'b000, 2'b00, 1'b0, 1'b1);
        check("p4_sticky_reset_block", 32'(if_b.block), 32'd0);
        check("p4_sticky_reset_cnt",   32'(if_b.stall_cnt), 32'd0);

        // Threshold of one, then reset mid-window.
        step(3'b000, 2'b00, 1'b1, 1'b0);
        check("p5_t1_block", 32'(if_c.block), 32'd1);
        check("p5_t1_pulse", 32'(if_c.block_pulse), 32'd1);
        step(3'b000, 2'b00, 1'b1, 1'b0);
        check("p5_cnt2", 32'(if_a.stall_cnt), 32'd2);
        step(3'b000, 2'b00, 1'b1, 1'b1);
        check("p5_reset_cnt",   32'(if_a.stall_cnt), 32'd0);
        check("p5_reset_block", 32'(if_a.block), 32'd0);

        // Randomized: mostly-held patterns with occasional changes, idles and resets.
        r_axis = 3'b001; r_idle = 2'b00; r_blk = 1'b0;
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 8) begin
                r_axis = 3'($urandom); r_idle = 2'($urandom); r_blk = 1'($urandom);
            end else if (r < 12) begin
                r_axis = 3'b000; r_blk = 1'b0;
            end else if (r < 14) begin
                r_idle = 2'($urandom);
            end
            step(r_axis, r_idle, r_blk, (r == 99) ? 1'b1 : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
